// File: rtl/vrf_read_responder_if.sv
// rtl/vrf_read_responder_if.sv - read-request, write and result signal bundle for vrf_read_responder
interface vrf_read_responder_if #(
    parameter int NUM_PORTS = 2,
    parameter int VS_W      = 5,
    parameter int OFFSET_W  = 6,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS-1:0]          req_ready;
    logic [NUM_PORTS*VS_W-1:0]     req_vs;
    logic [NUM_PORTS*OFFSET_W-1:0] req_offset;
    logic [NUM_PORTS*2-1:0]        req_readSource;
    logic [NUM_PORTS*3-1:0]        req_instructionIndex;

    logic                          wr_valid;
    logic [VS_W-1:0]               wr_vs;
    logic [OFFSET_W-1:0]           wr_offset;
    logic [DATA_W-1:0]             wr_data;
    logic [DATA_W/8-1:0]           wr_mask;

    logic [NUM_PORTS-1:0]          result_valid;
    logic [DATA_W-1:0]             result_data;
    logic [1:0]                    result_readSource;
    logic [2:0]                    result_instructionIndex;

    // Requesters and the write source drive requests; they observe ready and results
    modport master (
        output req_valid, req_vs, req_offset, req_readSource, req_instructionIndex,
        output wr_valid, wr_vs, wr_offset, wr_data, wr_mask,
        input  req_ready,
        input  result_valid, result_data, result_readSource, result_instructionIndex
    );

    // The responder owns ready and the result bus
    modport slave (
        input  req_valid, req_vs, req_offset, req_readSource, req_instructionIndex,
        input  wr_valid, wr_vs, wr_offset, wr_data, wr_mask,
        output req_ready,
        output result_valid, result_data, result_readSource, result_instructionIndex
    );
endinterface

// File: rtl/vrf_read_responder.sv
// rtl/vrf_read_responder.sv - round-robin VRF read responder with 2-cycle result and write port (option: VRF_READ_BYPASS_EN)
module vrf_read_responder #(
    parameter int NUM_PORTS = 2,
    parameter int VS_W      = 5,
    parameter int OFFSET_W  = 6,
    parameter int DATA_W    = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    vrf_read_responder_if.slave bus
);
    localparam int ADDR_W = VS_W + OFFSET_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MASK_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Storage is deliberately not reset
    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]       cand;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [NUM_PORTS-1:0] grant;
    logic [ADDR_W-1:0]    grant_addr;
    logic [1:0]           grant_rs;
    logic [2:0]           grant_ii;
    logic [ADDR_W-1:0]    wr_addr;
    logic                 read_block;
    logic                 fire;

    logic [NUM_PORTS-1:0] s1_valid_q;
    logic [ADDR_W-1:0]    s1_addr_q;
    logic [1:0]           s1_rs_q;
    logic [2:0]           s1_ii_q;
    logic [DATA_W-1:0]    s1_rdata;

    logic [NUM_PORTS-1:0] s2_valid_q;
    logic [DATA_W-1:0]    s2_data_q;
    logic [1:0]           s2_rs_q;
    logic [2:0]           s2_ii_q;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [MASK_W-1:0] mask);
        merge_bytes = old_w;
        for (int b = 0; b < MASK_W; b++) begin
            if (mask[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
        end
    endfunction

    assign wr_addr = {bus.wr_vs, bus.wr_offset};

    // Round-robin search starting at rr_ptr, then mux the winner's address and tags
    always_comb begin
        cand       = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        grant      = '0;
        grant_addr = '0;
        grant_rs   = '0;
        grant_ii   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_PORTS)) cand = cand - (PTR_W+1)'(NUM_PORTS);
            if (!grant_any && bus.req_valid[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_any && grant_idx == PTR_W'(p)) begin
                grant[p]   = 1'b1;
                grant_addr = {bus.req_vs[p*VS_W +: VS_W], bus.req_offset[p*OFFSET_W +: OFFSET_W]};
                grant_rs   = bus.req_readSource[p*2 +: 2];
                grant_ii   = bus.req_instructionIndex[p*3 +: 3];
            end
        end
    end

`ifdef VRF_READ_BYPASS_EN
    // Only a read to the word being written has to wait
    assign read_block = bus.wr_valid && (wr_addr == grant_addr);
`else
    // The write port steals the whole cycle
    assign read_block = bus.wr_valid;
`endif

    assign bus.req_ready = read_block ? '0 : grant;
    assign fire          = grant_any && !read_block;

    // Pointer moves just past the port that fired, otherwise holds
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

`ifdef VRF_READ_BYPASS_EN
    // S1 storage read, with same-cycle write bytes forwarded so the result sees the write
    always_comb begin
        s1_rdata = mem_q[s1_addr_q];
        if (bus.wr_valid && (wr_addr == s1_addr_q)) begin
            s1_rdata = merge_bytes(s1_rdata, bus.wr_data, bus.wr_mask);
        end
    end
`else
    // S1 storage read; a write committing this cycle is not yet visible
    always_comb begin
        s1_rdata = mem_q[s1_addr_q];
    end
`endif

    // Byte-masked write commits at the end of its cycle; ignored while in reset
    always_ff @(posedge clock) begin
        if (reset_n && bus.wr_valid) begin
            mem_q[wr_addr] <= merge_bytes(mem_q[wr_addr], bus.wr_data, bus.wr_mask);
        end
    end

    // Arbitration pointer and the two-stage read pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= '0;
            s1_addr_q  <= '0;
            s1_rs_q    <= '0;
            s1_ii_q    <= '0;
            s2_valid_q <= '0;
            s2_data_q  <= '0;
            s2_rs_q    <= '0;
            s2_ii_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= fire ? grant : '0;
            if (fire) begin
                s1_addr_q <= grant_addr;
                s1_rs_q   <= grant_rs;
                s1_ii_q   <= grant_ii;
            end
            s2_valid_q <= s1_valid_q;
            if (|s1_valid_q) begin
                s2_data_q <= s1_rdata;
                s2_rs_q   <= s1_rs_q;
                s2_ii_q   <= s1_ii_q;
            end
        end
    end

    assign bus.result_valid            = s2_valid_q;
    assign bus.result_data             = s2_data_q;
    assign bus.result_readSource       = s2_rs_q;
    assign bus.result_instructionIndex = s2_ii_q;
endmodule

// File: tb/tb_vrf_read_responder.sv
// tb/tb_vrf_read_responder.sv - scoreboard bench for vrf_read_responder with a reference model
module tb_vrf_read_responder;
    localparam int N     = 2;
    localparam int VS_W  = 5;
    localparam int OFF_W = 6;
    localparam int DW    = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    vrf_read_responder_if #(.NUM_PORTS(N), .VS_W(VS_W), .OFFSET_W(OFF_W), .DATA_W(DW)) bus();

    vrf_read_responder #(.NUM_PORTS(N), .VS_W(VS_W), .OFFSET_W(OFF_W), .DATA_W(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int           due;
        logic [N-1:0] onehot;
        int           addr;
        logic [31:0]  data;
        logic [1:0]   rs;
        logic [2:0]   ii;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [2048];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Monitor and reference model: observe inputs each cycle, predict ready and results
    initial begin : monitor
        exp_t e;
        int   rr;
        int   g;
        int   a;
        int   waddr;
        logic blocked;
        logic [N-1:0] exp_ready;
        rr = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                sbq.delete();
                rr = 0;
                chk("reset_result_valid", 64'(bus.result_valid), 64'd0);
                chk("reset_result_data", 64'(bus.result_data), 64'd0);
                chk("reset_result_tags", 64'({bus.result_readSource, bus.result_instructionIndex}), 64'd0);
                continue;
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("result_valid", 64'(bus.result_valid), 64'(e.onehot));
                chk("result_data", 64'(bus.result_data), 64'(e.data));
                chk("result_readSource", 64'(bus.result_readSource), 64'(e.rs));
                chk("result_instructionIndex", 64'(bus.result_instructionIndex), 64'(e.ii));
            end else begin
                chk("idle_result_valid", 64'(bus.result_valid), 64'd0);
            end

            g = -1;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (rr + k) % N;
                if (g < 0 && bus.req_valid[p]) g = p;
            end
            waddr = int'({bus.wr_vs, bus.wr_offset});
            a = 0;
            if (g >= 0) a = int'({bus.req_vs[g*VS_W +: VS_W], bus.req_offset[g*OFF_W +: OFF_W]});
`ifdef VRF_READ_BYPASS_EN
            blocked = bus.wr_valid && (g >= 0) && (a == waddr);
`else
            blocked = bus.wr_valid;
`endif
            exp_ready = (g >= 0 && !blocked) ? N'(1) << g : '0;
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));

            if (g >= 0 && !blocked) begin
                e.due    = cyc + 2;
                e.onehot = N'(1) << g;
                e.addr   = a;
                e.data   = ref_mem[a];
                e.rs     = bus.req_readSource[g*2 +: 2];
                e.ii     = bus.req_instructionIndex[g*3 +: 3];
                sbq.push_back(e);
                rr = (g + 1) % N;
            end
            if (bus.wr_valid) begin
`ifdef VRF_READ_BYPASS_EN
                foreach (sbq[i]) begin
                    if (sbq[i].due == cyc + 1 && sbq[i].addr == waddr)
                        sbq[i].data = mrg(sbq[i].data, bus.wr_data, bus.wr_mask);
                end
`endif
                ref_mem[waddr] = mrg(ref_mem[waddr], bus.wr_data, bus.wr_mask);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input int vs, input int off, input int rs, input int ii);
        bus.req_valid[p]                = v;
        bus.req_vs[p*VS_W +: VS_W]      = VS_W'(vs);
        bus.req_offset[p*OFF_W +: OFF_W] = OFF_W'(off);
        bus.req_readSource[p*2 +: 2]    = 2'(rs);
        bus.req_instructionIndex[p*3 +: 3] = 3'(ii);
    endtask

    task automatic set_wr(input logic v, input int vs, input int off, input logic [31:0] d, input logic [3:0] m);
        bus.wr_valid  = v;
        bus.wr_vs     = VS_W'(vs);
        bus.wr_offset = OFF_W'(off);
        bus.wr_data   = d;
        bus.wr_mask   = m;
    endtask

    task automatic idle_all();
        for (int p = 0; p < N; p++) set_req(p, 1'b0, 0, 0, 0, 0);
        set_wr(1'b0, 0, 0, 32'h0, 4'h0);
    endtask

    // Stimulus: directed scenarios, then randomized traffic with legal hold behaviour
    initial begin : driver
        logic [N-1:0] fired;
        idle_all();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        for (int vs = 0; vs < 4; vs++) begin
            for (int off = 0; off < 8; off++) begin
                set_wr(1'b1, vs, off, $urandom, 4'hF);
                tick();
            end
        end
        set_wr(1'b1, 3, 5, 32'hDEADBEEF, 4'hF);
        tick();
        set_wr(1'b1, 1, 0, 32'h11111111, 4'hF);
        tick();
        set_wr(1'b0, 0, 0, 32'h0, 4'h0);

        set_req(0, 1'b1, 3, 5, 2, 5);
        tick();
        idle_all();
        repeat (3) tick();

        set_req(0, 1'b1, 1, 0, 1, 3);
        tick();
        idle_all();
        set_wr(1'b1, 1, 0, 32'hAABBCCDD, 4'h3);
        tick();
        idle_all();
        repeat (3) tick();

        set_req(0, 1'b1, 0, 1, 0, 1);
        set_req(1, 1'b1, 2, 6, 3, 6);
        repeat (4) tick();
        set_wr(1'b1, 3, 7, 32'h01234567, 4'hF);
        tick();
        set_wr(1'b0, 0, 0, 32'h0, 4'h0);
        repeat (4) tick();
        idle_all();
        repeat (3) tick();

        set_req(1, 1'b1, 2, 2, 1, 2);
        tick();
        idle_all();
        set_req(1, 1'b1, 2, 3, 1, 2);
        tick();
        set_req(0, 1'b1, 0, 4, 2, 4);
        set_req(1, 1'b1, 2, 3, 1, 2);
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        idle_all();
        repeat (3) tick();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            fired = bus.req_valid & bus.req_ready;
            tick();
            reset_n = ($urandom_range(0, 399) != 0);
            for (int p = 0; p < N; p++) begin
                if (!bus.req_valid[p] || fired[p])
                    set_req(p, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                            $urandom_range(0, 3), $urandom_range(0, 7));
            end
            set_wr($urandom_range(0, 4) == 0, $urandom_range(0, 3), $urandom_range(0, 7),
                   $urandom, 4'($urandom_range(0, 15)));
        end
        reset_n = 1'b1;
        idle_all();
        repeat (5) tick();
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vrf_read_responder.md
Name: vrf_read_responder

Overview:
- Responder end of the lane VRF read-request interface.
- Accepts read requests (vs, offset, readSource, instructionIndex) from NUM_PORTS read pipes and arbitrates them round-robin onto one storage read port.
- Returns the 32-bit element on a shared result bus exactly 2 cycles after request fire, with a one-hot valid naming the requesting pipe.
- Also owns the single write port into the same storage. A write has priority over all reads in its cycle.

Parameters:
- NUM_PORTS, 2, number of read requesters (1..8).
- VS_W, 5, register-index width (32 vector registers).
- OFFSET_W, 6, per-register offset width. Storage depth is 2^(VS_W+OFFSET_W) words.
- DATA_W, 32, element width.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request ready.
- req_vs  in  NUM_PORTS*VS_W  packed per-port register index; port p occupies bits [p*VS_W +: VS_W].
- req_offset  in  NUM_PORTS*OFFSET_W  packed per-port offset.
- req_readSource  in  NUM_PORTS*2  packed per-port read-source tag.
- req_instructionIndex  in  NUM_PORTS*3  packed per-port instruction tag.
- wr_valid  in  1  write strobe. Always accepted, no ready.
- wr_vs  in  VS_W  write register index.
- wr_offset  in  OFFSET_W  write offset.
- wr_data  in  DATA_W  write data.
- wr_mask  in  DATA_W/8  byte enables.
- result_valid  out  NUM_PORTS  one-hot; the port whose request fired 2 cycles earlier.
- result_data  out  DATA_W  read data.
- result_readSource  out  2  tag echoed from the fired request.
- result_instructionIndex  out  3  tag echoed from the fired request.

Behaviour:
- Address: address = {vs, offset}. Storage is not reset; reads of unwritten words return X.
- Arbitration:
  - rr_ptr (log2 NUM_PORTS bits) names the highest-priority port.
  - Grant goes to the first valid port at or after rr_ptr, with wrap-around.
  - req_ready[p] = grant[p] & ~read_block. At most one ready bit is high per cycle.
  - Fire = req_valid[p] & req_ready[p].
  - On fire, rr_ptr <= (granted port + 1) mod NUM_PORTS. Without a fire, rr_ptr holds.
- Handshake rules:
  - req_ready may depend combinationally on any req_valid.
  - Requesters must not drop valid, or change bits, while valid && !ready.
- Write priority: read_block = wr_valid (base build). While it is high, no read fires and rr_ptr holds.
- Write timing: a write commits at the posedge of its cycle, byte-masked. A read firing in any later cycle returns the new data.
- Pipeline:
  - S1 registers: valid one-hot, address, tags. The storage read happens in S1.
  - S2 registers: valid one-hot, data, tags. These drive the result_* outputs.
  - Latency is fixed at 2 cycles, with no result backpressure. The requester must reserve space before it asserts valid.
  - Throughput is 1 read per cycle.
- Output idle values: result_valid = 0 whenever there is no fire 2 cycles prior. result_data and tags are don't-care when result_valid = 0.
- Reset:
  - Asserting reset_n low clears S1/S2 valids and rr_ptr = 0 immediately (asynchronously). Outputs go to result_valid = 0, result_data = 0, tags = 0.
  - In-flight reads are dropped and produce no result.
  - Writes are ignored while in reset.
  - The first fire can occur in the first cycle after reset deassertion.
- Simultaneous events: a fire in cycle T and a write to the same address in T+1 → the result carries the pre-write data, because the read was taken in S1 before the write committed.

Optional Feature:
- Macro: VRF_READ_BYPASS_EN.
- Defined:
  - read_block = wr_valid & (write address == granted port's address). Reads to other addresses proceed in parallel with the write.
  - No same-address read fires alongside a write.
  - A fire in T with a same-address write in T+1 forwards the masked write bytes into S2. The result then reflects the write, merged byte-wise.
- Undefined: base behaviour as above (any write blocks all reads; no forwarding).

Test Plan:
- Write vs=3 off=5 data=0xDEADBEEF mask=0xF in cycle 0; port0 reads vs=3 off=5 in cycle 1 → result_valid=0b01 and result_data=0xDEADBEEF in cycle 3, with readSource and instructionIndex echoed.
- Both ports valid continuously after reset → grants alternate 0,1,0,1; result_valid alternates 0b01, 0b10 from cycle 2 with one result per cycle.
- wr_valid=1 in cycle 4 with both ports valid → req_ready=0 in cycle 4; rr_ptr unchanged; no result_valid in cycle 6.
- Fire on vs=1 off=0 (holding 0x11111111) in cycle T; write 0xAABBCCDD mask=0x3 to the same address in T+1 → base build: 0x11111111 at T+2; VRF_READ_BYPASS_EN build: 0x1111CCDD.
- reset_n low in the cycle after a fire → result_valid stays 0 for the following cycles; rr_ptr=0 after release; the next fire goes to port0 if it is valid.
- NUM_PORTS=1, back-to-back reads at offsets 0..63 of vs=31 → 64 results in consecutive cycles, in order.
